// File: rtl/capture_packer_if.sv
// Word stream from the capture packer to the DMA write engine.
interface capture_packer_if;
    // A word transfers on a rising edge where m_valid_o && m_ready_i; while m_valid_o is high and
    // m_ready_i is low, m_data_o/m_last_o hold steady and m_valid_o does not drop.
    logic [63:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        m_last_o;

    modport master (output m_data_o, output m_valid_o, output m_last_o, input m_ready_i);
    modport slave  (input m_data_o, input m_valid_o, input m_last_o, output m_ready_i);
endinterface

// File: rtl/capture_packer.sv
// ADC A/B capture front end: decimate, pack two sign-extended pairs per 64-bit word,
// buffer in a FIFO and deliver exactly len words per armed capture.
module capture_packer #(
    parameter int SAMPLE_WIDTH = 14,
    parameter int LEN_WIDTH    = 24,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm_i,
    input  logic [15:0]             decim_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    input  logic [SAMPLE_WIDTH-1:0] smp_a_i,
    input  logic [SAMPLE_WIDTH-1:0] smp_b_i,
    input  logic                    smp_valid_i,
    capture_packer_if.master        stream,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overflow_o,
    output logic [LEN_WIDTH-1:0]    word_cnt_o,
    output logic [1:0]              state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    state_t                  state;
    logic                    busy_q, done_q, overflow_q;
    logic [LEN_WIDTH-1:0]    word_cnt, len_q;
    logic [15:0]             decim_q, dec_cnt;
    logic [31:0]             half_q;
    logic                    half_full;
    logic [63:0]             word_q;
    logic                    push_pend;

    logic [64:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;

    logic                    full, fifo_valid, push_ok, pop, last_tag, head_last;
    logic [LEN_WIDTH-1:0]    word_cnt_next;
    logic [31:0]             pair;

    function automatic logic [15:0] sext16(input logic [SAMPLE_WIDTH-1:0] x);
        return {{(16 - SAMPLE_WIDTH){x[SAMPLE_WIDTH-1]}}, x};
    endfunction

    assign pair          = {sext16(smp_b_i), sext16(smp_a_i)};
    assign full          = (count == FULL_CNT);
    assign fifo_valid    = (count != '0);
    assign push_ok       = push_pend && !full;
    assign pop           = fifo_valid && stream.m_ready_i;
    assign word_cnt_next = word_cnt + 1'b1;
    assign last_tag      = (word_cnt_next == len_q);
    assign head_last     = mem[rd_ptr][64];

    assign stream.m_valid_o = fifo_valid;
    assign stream.m_data_o  = fifo_valid ? mem[rd_ptr][63:0] : '0;
    assign stream.m_last_o  = fifo_valid && head_last;

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;
    assign word_cnt_o = word_cnt;
    assign state_o    = state;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {last_tag, word_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            word_cnt   <= '0;
            len_q      <= '0;
            decim_q    <= '0;
            dec_cnt    <= '0;
            half_q     <= '0;
            half_full  <= 1'b0;
            word_q     <= '0;
            push_pend  <= 1'b0;
        end else begin
            push_pend <= 1'b0;
            // A completed word landing on a full FIFO is dropped without advancing the count.
            if (push_pend) begin
                if (full) overflow_q <= 1'b1;
                else      word_cnt   <= word_cnt_next;
            end

            unique case (state)
                IDLE, DONE: begin
                    if (arm_i) begin
                        len_q      <= len_i;
                        decim_q    <= decim_i;
                        overflow_q <= 1'b0;
                        word_cnt   <= '0;
                        half_full  <= 1'b0;
                        dec_cnt    <= '0;
                        push_pend  <= 1'b0;
                        if (len_i != '0) begin
                            state  <= CAPTURE;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                        end else begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (push_ok && last_tag) begin
                        state <= DRAIN;
                    end else if (smp_valid_i) begin
                        if (dec_cnt == '0) begin
                            dec_cnt <= decim_q;
                            if (half_full) begin
                                word_q    <= {pair, half_q};
                                push_pend <= 1'b1;
                                half_full <= 1'b0;
                            end else begin
                                half_q    <= pair;
                                half_full <= 1'b1;
                            end
                        end else begin
                            dec_cnt <= dec_cnt - 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_capture_packer.sv
// Directed-vector bench for capture_packer with an expected-word queue checked by a stream monitor.
module tb_capture_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic        arm_i;
    logic [15:0] decim_i;
    logic [23:0] len_i;
    logic [13:0] smp_a_i, smp_b_i;
    logic        smp_valid_i;
    logic        busy_o, done_o, overflow_o;
    logic [23:0] word_cnt_o;
    logic [1:0]  state_o;

    capture_packer_if stream ();

    capture_packer #(.SAMPLE_WIDTH(14), .LEN_WIDTH(24), .FIFO_DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm_i      (arm_i),
        .decim_i    (decim_i),
        .len_i      (len_i),
        .smp_a_i    (smp_a_i),
        .smp_b_i    (smp_b_i),
        .smp_valid_i(smp_valid_i),
        .stream     (stream.master),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .overflow_o (overflow_o),
        .word_cnt_o (word_cnt_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [64:0] exp_q[$];

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && stream.m_valid_o && stream.m_ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: got last=%0b data=%h, expected none",
                         stream.m_last_o, stream.m_data_o);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                if ({stream.m_last_o, stream.m_data_o} !== e) begin
                    n_err++;
                    $display("FAIL stream_word: got last=%0b data=%h, expected last=%0b data=%h",
                             stream.m_last_o, stream.m_data_o, e[64], e[63:0]);
                end
            end
        end
    end

    // ---------------- helpers / driver tasks ----------------
    function automatic logic [31:0] pk(input logic [13:0] a, input logic [13:0] b);
        return {{2{b[13]}}, b, {2{a[13]}}, a};
    endfunction

    function automatic logic [63:0] wd(input logic [13:0] a0, input logic [13:0] b0,
                                       input logic [13:0] a1, input logic [13:0] b1);
        return {pk(a1, b1), pk(a0, b0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_arm(input logic [23:0] len, input logic [15:0] decim);
        arm_i   = 1'b1;
        len_i   = len;
        decim_i = decim;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic send_pair(input logic [13:0] a, input logic [13:0] b);
        smp_a_i     = a;
        smp_b_i     = b;
        smp_valid_i = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (done_o) break;
            tick();
        end
        chk(name, {63'd0, done_o}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [13:0] av [8];
        logic [13:0] bv [8];
        logic        seen;

        rst = 1'b1; arm_i = 1'b0; decim_i = '0; len_i = '0;
        smp_a_i = '0; smp_b_i = '0; smp_valid_i = 1'b0;
        stream.m_ready_i = 1'b1;
        repeat (3) tick();
        chk("reset_valid", {63'd0, stream.m_valid_o}, 64'd0);
        chk("reset_busy_done", {62'd0, busy_o, done_o}, 64'd0);
        rst = 1'b0;
        tick();

        // Basic: A=n, B=-n
        for (int n = 0; n < 8; n++) begin
            av[n] = 14'(n);
            bv[n] = 14'(-n);
        end
        exp_q.push_back({1'b0, 64'hFFFF_0001_0000_0000});
        for (int k = 1; k < 4; k++)
            exp_q.push_back({(k == 3), wd(av[2*k], bv[2*k], av[2*k+1], bv[2*k+1])});
        do_arm(24'd4, 16'd0);
        chk("busy_after_arm", {63'd0, busy_o}, 64'd1);
        for (int n = 0; n < 8; n++) send_pair(av[n], bv[n]);
        smp_valid_i = 1'b0;
        wait_done("basic_done", 40);
        chk("basic_busy_low", {63'd0, busy_o}, 64'd0);
        chk("basic_word_cnt", {40'd0, word_cnt_o}, 64'd4);

        // Sign extension
        exp_q.push_back({1'b1, 64'hFFFF_0005_1FFF_E000});
        do_arm(24'd1, 16'd0);
        send_pair(14'h2000, 14'h1FFF);
        send_pair(14'h0005, 14'h3FFF);
        smp_valid_i = 1'b0;
        wait_done("sign_done", 40);

        // Decimation: keep samples 0,3,6,9
        exp_q.push_back({1'b0, 64'h0000_0003_0000_0000});
        exp_q.push_back({1'b1, 64'h0000_0009_0000_0006});
        do_arm(24'd2, 16'd2);
        for (int i = 0; i < 12; i++) send_pair(14'(i), 14'd0);
        smp_valid_i = 1'b0;
        wait_done("decim_done", 40);
        chk("decim_word_cnt", {40'd0, word_cnt_o}, 64'd2);

        // Zero length
        do_arm(24'd0, 16'd0);
        chk("len0_done", {63'd0, done_o}, 64'd1);
        chk("len0_busy", {63'd0, busy_o}, 64'd0);
        seen = 1'b0;
        repeat (5) begin seen |= stream.m_valid_o; tick(); end
        chk("len0_no_valid", {63'd0, seen}, 64'd0);

        // Arm pulse during CAPTURE is ignored
        exp_q.push_back({1'b0, wd(14'd10, 14'd20, 14'd11, 14'd21)});
        exp_q.push_back({1'b1, wd(14'd12, 14'd22, 14'd13, 14'd23)});
        do_arm(24'd2, 16'd0);
        send_pair(14'd10, 14'd20);
        send_pair(14'd11, 14'd21);
        arm_i = 1'b1; len_i = 24'd5;
        send_pair(14'd12, 14'd22);
        arm_i = 1'b0;
        for (int i = 13; i < 16; i++) send_pair(14'(i), 14'(i + 10));
        smp_valid_i = 1'b0;
        wait_done("rearm_done", 40);
        chk("rearm_word_cnt", {40'd0, word_cnt_o}, 64'd2);

        // Backpressure / overflow: 40 words of samples with ready low
        stream.m_ready_i = 1'b0;
        for (int k = 0; k < 16; k++)
            exp_q.push_back({1'b0, wd(14'(2*k), 14'(500 + 2*k), 14'(2*k + 1), 14'(501 + 2*k))});
        do_arm(24'd32, 16'd0);
        for (int i = 0; i < 80; i++) send_pair(14'(i), 14'(500 + i));
        smp_valid_i = 1'b0;
        repeat (4) tick();
        chk("ovf_flag", {63'd0, overflow_o}, 64'd1);
        chk("ovf_word_cnt_full", {40'd0, word_cnt_o}, 64'd16);
        chk("ovf_valid_held", {63'd0, stream.m_valid_o}, 64'd1);
        stream.m_ready_i = 1'b1;
        repeat (24) tick();
        chk("ovf_first16_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
        for (int k = 0; k < 16; k++)
            exp_q.push_back({(k == 15), wd(14'(1000 + 2*k), 14'(2000 + 2*k),
                                           14'(1001 + 2*k), 14'(2001 + 2*k))});
        for (int i = 0; i < 32; i++) send_pair(14'(1000 + i), 14'(2000 + i));
        smp_valid_i = 1'b0;
        wait_done("ovf_done", 60);
        chk("ovf_word_cnt", {40'd0, word_cnt_o}, 64'd32);
        chk("ovf_sticky", {63'd0, overflow_o}, 64'd1);

        // Reset mid-capture after 3 words pushed
        stream.m_ready_i = 1'b0;
        do_arm(24'd8, 16'd0);
        for (int i = 0; i < 6; i++) send_pair(14'(i + 40), 14'(i + 60));
        smp_valid_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (word_cnt_o == 24'd3) break;
            tick();
        end
        chk("rst_pre_word_cnt", {40'd0, word_cnt_o}, 64'd3);
        rst = 1'b1;
        tick();
        chk("rst_stream", {stream.m_data_o[62:0], stream.m_valid_o}, 64'd0);
        chk("rst_data_msb_last", {62'd0, stream.m_data_o[63], stream.m_last_o}, 64'd0);
        chk("rst_flags", {61'd0, busy_o, done_o, overflow_o}, 64'd0);
        chk("rst_word_cnt", {40'd0, word_cnt_o}, 64'd0);
        rst = 1'b0;
        stream.m_ready_i = 1'b1;
        tick();
        chk("rst_fifo_empty", {63'd0, stream.m_valid_o}, 64'd0);
        exp_q.push_back({1'b1, wd(14'd7, 14'd8, 14'd9, 14'h3FF0)});
        do_arm(24'd1, 16'd0);
        send_pair(14'd7, 14'd8);
        send_pair(14'd9, 14'h3FF0);
        smp_valid_i = 1'b0;
        wait_done("post_rst_done", 40);
        tick();
        chk("post_rst_empty", {63'd0, stream.m_valid_o}, 64'd0);
        chk("post_rst_word_cnt", {40'd0, word_cnt_o}, 64'd1);

        chk("exp_q_empty", {32'd0, 32'(exp_q.size())}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/capture_packer.md
# capture_packer

Sample-capture front end for the HP0 DMA path. Takes the 14-bit ADC A/B sample stream in the pdh_core clock domain, applies a programmable decimation, packs two A/B pairs into each 64-bit beat, and buffers the beats in a small FIFO. The FIFO drains through a valid/ready stream to the DMA write engine. One armed capture delivers exactly `len_i` words, with `m_last_o` on the final word.

## Interface
- `SAMPLE_WIDTH`, 14: ADC sample width, signed two's complement.
- `LEN_WIDTH`, 24: width of the capture length, in 64-bit words.
- `FIFO_DEPTH`, 16: FIFO depth in 64-bit words; power of 2, minimum 4.

- `clk` in 1: pdh_clk; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `arm_i` in 1: single-cycle start pulse.
- `decim_i` in 16: keep 1 of every `decim_i+1` valid samples; sampled at arm.
- `len_i` in LEN_WIDTH: words to deliver; sampled at arm.
- `smp_a_i` in SAMPLE_WIDTH: channel A sample.
- `smp_b_i` in SAMPLE_WIDTH: channel B sample.
- `smp_valid_i` in 1: sample pair valid this cycle; cannot be back-pressured.
- `m_data_o` out 64: packed word.
- `m_valid_o` out 1: word available.
- `m_ready_i` in 1: consumer accepts the word.
- `m_last_o` out 1: current word is the final word of the capture.
- `busy_o` out 1: FSM is in CAPTURE or DRAIN.
- `done_o` out 1: FSM is in DONE.
- `overflow_o` out 1: sticky flag; at least one word was dropped since the last arm.
- `word_cnt_o` out LEN_WIDTH: words pushed into the FIFO during this capture.

## Operation
- **Packing**
  - Each kept pair forms `{sext16(b), sext16(a)}` (32 bits).
  - The first pair of a word goes to [31:0], the second to [63:32].
- **Decimation counter**
  - The first valid sample after arm is kept.
  - On a keep, the counter reloads to `decim_i`.
  - On a non-kept valid sample, the counter decrements.
  - Invalid cycles do not change the counter.
- **FSM: IDLE -> CAPTURE -> DRAIN -> DONE**
  - IDLE/DONE: `arm_i` latches `len`/`decim` and clears `overflow_o`, `word_cnt_o`, the half-word register and the decimation counter.
    - Go to CAPTURE if `len_i != 0`; otherwise go directly to DONE.
  - CAPTURE: build words. When `word_cnt` reaches `len`, go to DRAIN.
    - Samples arriving after that point are ignored.
    - A half-filled word is never emitted.
  - DRAIN: stop accepting samples. Go to DONE on the handshake of the word carrying `m_last_o`.
  - DONE: hold `done_o=1` until the next `arm_i`.
  - `arm_i` in CAPTURE or DRAIN is ignored.
- **Overflow**
  - A word completed while the FIFO is full is discarded and `overflow_o` is set.
  - `word_cnt` does not advance, so exactly `len` words are still delivered and the capture continues.
  - "Full" is the registered flag; a pop in the same cycle does not rescue the push.
- **`m_last_o`**
  - Tagged in the FIFO alongside the word whose push makes `word_cnt == len`.
- **Reset** (any state, including mid-capture):
  - FSM goes to IDLE and the FIFO is emptied.
  - All outputs go to 0: `m_data_o`, `m_valid_o`, `m_last_o`, `busy_o`, `done_o`, `overflow_o`, `word_cnt_o`.

## Timing
- Word push occurs in the cycle after the clock edge that accepts the second pair of the word.
- `m_valid_o` rises 1 cycle after a push into an empty FIFO (registered output), so total latency from second-pair accept to `m_valid_o` is 2 cycles.
- Stream rules (standard valid/ready):
  - The transfer happens on a clock edge where `m_valid_o && m_ready_i`.
  - `m_data_o` and `m_last_o` stay stable while valid is high and ready is low.
  - `m_valid_o` never drops without a handshake.
- Throughput: 1 word per cycle with `m_ready_i` held high; the FIFO supports simultaneous push and pop when not full.
- `busy_o` rises the cycle after `arm_i`.
- `done_o` rises the cycle after the final handshake; `busy_o` falls in the same cycle.
- `word_cnt_o` updates in the cycle after each push.

## Test plan
- **Basic:** `decim=0`, `len=4`, `smp_valid_i` continuous, A=n, B=-n for n=0..7, `m_ready_i=1`.
  - Expect 4 words, e.g. word0 = 0xFFFF_0001_0000_0000.
  - Expect `m_last_o` only on word3, then `done_o=1`.
- **Sign extension:** A=0x2000, B=0x1FFF.
  - Expect the low half of word0 = 0x1FFF_E000.
- **Decimation:** `decim=2`, A = sample index, `len=2`.
  - Expect kept A values 0, 3, 6, 9 packed into 2 words.
  - Expect `word_cnt_o=2` at DONE.
- **Backpressure/overflow:** `len=32`, `m_ready_i=0` for 40 words' worth of samples, then 1.
  - Expect `overflow_o=1`, exactly 32 words delivered, the first 16 contiguous, `m_last_o` on the 32nd.
- **Edge control:** `len=0`.
  - Expect DONE next cycle with no `m_valid_o`.
  - `arm_i` pulsed during CAPTURE: no restart.
- **Reset mid-capture:** `rst=1` after 3 words pushed.
  - Expect all outputs 0 on the next cycle and the FIFO empty.
  - A new arm with `len=1` delivers one word with `m_last_o=1`.
